led_pattern_ctrl: RTL and testbench
===================================

Name: led_pattern_ctrl

Overview:
Sequencer driving the board's 4-bit LED bank. It divides the system clock into a step rate and generates one of four display patterns. Pattern changes arrive through a req/ack handshake and take effect only on step boundaries, so the LEDs never glitch mid-step. It sits between the top-level control logic (keys/UART decoder) and the led[3:0] pins.

Parameters:
STEP_CYCLES, 25000000, clk cycles per pattern step (0.5 s at 50 MHz); legal range 2..2^32-1.
CNT_W, 32, prescaler counter width; must hold STEP_CYCLES-1.

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
mode_req  input  1  one-cycle request to change pattern
mode_sel  input  2  requested mode, sampled when mode_req=1
pause  input  1  level; while 1, the prescaler and pattern freeze
mode_ack  output  1  one-cycle pulse when a pending mode is applied
step_tick  output  1  one-cycle pulse on every cycle in which led changes step
cur_mode  output  2  currently applied mode
led  output  4  LED drive, active-high

Behaviour:
- Reset (async, rst_n=0): led=4'b0000, cur_mode=OFF, mode_ack=0, step_tick=0, prescaler cnt=0, pend_valid=0, dir=LEFT. All registers clear immediately on reset assertion, including mid-step or mid-handshake. Any pending request is lost.
- Modes: 0 OFF (led=0000, constant). 1 SHIFT_L (0001→0010→0100→1000→0001). 2 PINGPONG (0001→0010→0100→1000→0100→0010→0001…; dir flips at 1000 and at 0001, and no LED is repeated at the ends). 3 BLINK (1111↔0000).
- Prescaler: cnt counts 0..STEP_CYCLES-1 and wraps to 0. The internal tick = (cnt==STEP_CYCLES-1) && !pause. While pause=1, cnt holds. Releasing pause resumes from the held value.
- On the clock edge where tick=1:
  - If pend_valid: cur_mode<=pend_mode; led<=initial pattern of that mode (OFF 0000, SHIFT_L 0001, PINGPONG 0001, BLINK 1111); dir<=LEFT; pend_valid<=0; mode_ack<=1.
  - Otherwise: led advances one step per cur_mode.
  - step_tick<=1 in both cases, and it stays high for exactly the one cycle in which the new led value is first visible.
- Latency: a mode_req waits for the next tick. The new pattern appears 1 cycle after the tick cycle and coincides with mode_ack and step_tick. Worst case is STEP_CYCLES cycles after the request, or longer while paused.
- Handshake:
  - mode_req sets pend_valid=1 and pend_mode=mode_sel.
  - Several requests before a tick: the last one wins, and only one ack is issued.
  - A request on the same cycle as a tick is NOT applied at that tick. It becomes pending and is applied at the following tick.
  - A request whose mode equals cur_mode is still applied: the pattern restarts and an ack is issued.
  - Requests during pause are accepted and applied at the first tick after pause is released.
- mode_ack and step_tick are registered outputs and never stay high for more than one cycle at a time.
- Width rules: cnt compare uses CNT_W bits. The STEP_CYCLES-1 constant is computed as a CNT_W-bit value.
- Illegal state safety: if led ever holds a value outside the current mode's sequence, the next tick loads the mode's initial pattern.

Decomposition:
- Shared package led_pkg holds:
  - Mode encodings MODE_OFF=0, MODE_SHIFT_L=1, MODE_PINGPONG=2, MODE_BLINK=3.
  - Initial-pattern constants.
  - Dir encoding LEFT=0, RIGHT=1.
- One sub-module: led_step_prescaler (parameter STEP_CYCLES, CNT_W; ports clk, rst_n, pause, tick). The top module holds the mode/pend/dir registers and the pattern next-state logic.

Test Plan:
All scenarios use STEP_CYCLES=4 and a 20 ns clock.
1. Reset, then run 20 cycles with no request -> led stays 0000 and cur_mode=0; step_tick pulses every 4 cycles; mode_ack never asserts.
2. mode_req with mode_sel=1 at cycle 1 after reset -> mode_ack and step_tick high together, led=0001. Following ticks give 0010, 0100, 1000, 0001.
3. Request PINGPONG -> led sequence over 8 ticks is 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
4. Request BLINK, then mode_req=1 for 2 consecutive cycles with mode_sel=2 then 3, both before the tick -> a single mode_ack; cur_mode=3; led=1111 then 0000 at the next tick.
5. In SHIFT_L at led=0100, assert pause for 10 cycles -> led and cnt frozen, no step_tick. mode_req with sel=0 during the pause is applied at the first tick after release: led=0000 with a single ack.
6. mode_req on the exact tick cycle -> that tick advances the old pattern with no ack; the next tick applies the new mode. Assert rst_n=0 mid-step -> led=0000, cur_mode=0, and the pending request is dropped (no ack after rst_n=1).

Source files
------------

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared mode, direction and pattern definitions for the LED sequencer
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_SHIFT_L  = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_BLINK    = 2'd3
  } mode_e;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_e;

  localparam logic [3:0] INIT_OFF      = 4'b0000;
  localparam logic [3:0] INIT_SHIFT_L  = 4'b0001;
  localparam logic [3:0] INIT_PINGPONG = 4'b0001;
  localparam logic [3:0] INIT_BLINK    = 4'b1111;

  // First pattern shown when a mode is (re)applied, also the recovery value
  function automatic logic [3:0] init_pattern(input mode_e m);
    case (m)
      MODE_SHIFT_L:  return INIT_SHIFT_L;
      MODE_PINGPONG: return INIT_PINGPONG;
      MODE_BLINK:    return INIT_BLINK;
      default:       return INIT_OFF;
    endcase
  endfunction

endpackage

// File: rtl/led_step_prescaler.sv
// rtl/led_step_prescaler.sv - divides clk into a pausable one-cycle step tick
module led_step_prescaler
  import led_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 25000000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pause,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Tick is combinational so the top registers its effects on the same edge the counter wraps
  always_comb begin
    tick = (cnt == LAST) && !pause;
  end

  // Count 0..LAST and wrap; hold the value while paused so a release resumes mid-step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!pause) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - LED bank sequencer with step-aligned mode change handshake
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 25000000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_req,
  input  logic [1:0] mode_sel,
  input  logic       pause,
  output logic       mode_ack,
  output logic       step_tick,
  output logic [1:0] cur_mode,
  output logic [3:0] led
);

  logic       tick;
  mode_e      cur_mode_q;
  mode_e      pend_mode;
  logic       pend_valid;
  dir_e       dir;
  logic [3:0] next_led;
  dir_e       next_dir;

  led_step_prescaler #(
    .STEP_CYCLES (STEP_CYCLES),
    .CNT_W       (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .pause (pause),
    .tick  (tick)
  );

  assign cur_mode = cur_mode_q;

  // Next step of the running pattern; any value off the sequence falls back to the initial pattern
  always_comb begin
    next_led = init_pattern(cur_mode_q);
    next_dir = LEFT;
    case (cur_mode_q)
      MODE_SHIFT_L: begin
        case (led)
          4'b0001: next_led = 4'b0010;
          4'b0010: next_led = 4'b0100;
          4'b0100: next_led = 4'b1000;
          4'b1000: next_led = 4'b0001;
          default: next_led = INIT_SHIFT_L;
        endcase
      end
      MODE_PINGPONG: begin
        // The ends turn around immediately so the end LEDs are never shown twice in a row
        case (led)
          4'b0001: begin next_led = 4'b0010; next_dir = LEFT;  end
          4'b0010: begin next_led = (dir == LEFT) ? 4'b0100 : 4'b0001; next_dir = dir; end
          4'b0100: begin next_led = (dir == LEFT) ? 4'b1000 : 4'b0010; next_dir = dir; end
          4'b1000: begin next_led = 4'b0100; next_dir = RIGHT; end
          default: begin next_led = INIT_PINGPONG; next_dir = LEFT; end
        endcase
      end
      MODE_BLINK: begin
        next_led = (led == 4'b1111) ? 4'b0000 : 4'b1111;
      end
      default: begin
        next_led = INIT_OFF;
      end
    endcase
  end

  // Mode/pending/direction state and registered outputs; pending requests only land on a tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led        <= INIT_OFF;
      cur_mode_q <= MODE_OFF;
      pend_mode  <= MODE_OFF;
      pend_valid <= 1'b0;
      dir        <= LEFT;
      mode_ack   <= 1'b0;
      step_tick  <= 1'b0;
    end else begin
      step_tick <= tick;
      mode_ack  <= 1'b0;
      if (tick) begin
        if (pend_valid) begin
          cur_mode_q <= pend_mode;
          led        <= init_pattern(pend_mode);
          dir        <= LEFT;
          pend_valid <= 1'b0;
          mode_ack   <= 1'b1;
        end else begin
          led <= next_led;
          dir <= next_dir;
        end
      end
      // Placed after the tick branch: a request on a tick cycle survives to the following tick
      if (mode_req) begin
        pend_valid <= 1'b1;
        pend_mode  <= mode_e'(mode_sel);
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - directed scoreboard bench for led_pattern_ctrl
module tb_led_pattern_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode_req = 1'b0;
  logic [1:0] mode_sel = 2'd0;
  logic       pause = 1'b0;
  logic       mode_ack;
  logic       step_tick;
  logic [1:0] cur_mode;
  logic [3:0] led;

  typedef struct packed {
    logic [3:0] led;
    logic       ack;
    logic [1:0] mode;
  } exp_t;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;

  led_pattern_ctrl #(
    .STEP_CYCLES (4),
    .CNT_W       (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_req  (mode_req),
    .mode_sel  (mode_sel),
    .pause     (pause),
    .mode_ack  (mode_ack),
    .step_tick (step_tick),
    .cur_mode  (cur_mode),
    .led       (led)
  );

  always #10 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_step(input string tag, input logic [3:0] l, input logic a,
                             input logic [1:0] m, input int gap_exp);
    int   gap;
    exp_t e;
    gap = 0;
    exp_q.push_back({l, a, m});
    do begin
      @(negedge clk);
      gap++;
      if (!step_tick) check({tag, " idle_ack"}, {7'd0, mode_ack}, 8'd0);
    end while (!step_tick && gap < 40);
    e = exp_q.pop_front();
    check({tag, " step_tick"}, {7'd0, step_tick}, 8'd1);
    check({tag, " led"},  {4'd0, led},      {4'd0, e.led});
    check({tag, " ack"},  {7'd0, mode_ack}, {7'd0, e.ack});
    check({tag, " mode"}, {6'd0, cur_mode}, {6'd0, e.mode});
    if (gap_exp != 0) check({tag, " gap"}, gap[7:0], gap_exp[7:0]);
  endtask

  task automatic req(input logic [1:0] s);
    mode_req = 1'b1;
    mode_sel = s;
    @(negedge clk);
    mode_req = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check({tag, " rst_led"},  {4'd0, led},       8'd0);
    check({tag, " rst_mode"}, {6'd0, cur_mode},  8'd0);
    check({tag, " rst_ack"},  {7'd0, mode_ack},  8'd0);
    check({tag, " rst_step"}, {7'd0, step_tick}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: idle after reset, OFF steps every 4 cycles, no ack
    do_reset("s1");
    for (int i = 0; i < 5; i++) expect_step("s1_off", 4'b0000, 1'b0, 2'd0, 4);

    // 2: SHIFT_L requested right after reset
    do_reset("s2");
    req(2'd1);
    expect_step("s2_apply", 4'b0001, 1'b1, 2'd1, 0);
    expect_step("s2_a", 4'b0010, 1'b0, 2'd1, 4);
    expect_step("s2_b", 4'b0100, 1'b0, 2'd1, 4);
    expect_step("s2_c", 4'b1000, 1'b0, 2'd1, 4);
    expect_step("s2_wrap", 4'b0001, 1'b0, 2'd1, 4);

    // 3: PINGPONG turns around at both ends without repeating
    req(2'd2);
    expect_step("s3_apply", 4'b0001, 1'b1, 2'd2, 0);
    expect_step("s3_1", 4'b0010, 1'b0, 2'd2, 4);
    expect_step("s3_2", 4'b0100, 1'b0, 2'd2, 4);
    expect_step("s3_3", 4'b1000, 1'b0, 2'd2, 4);
    expect_step("s3_4", 4'b0100, 1'b0, 2'd2, 4);
    expect_step("s3_5", 4'b0010, 1'b0, 2'd2, 4);
    expect_step("s3_6", 4'b0001, 1'b0, 2'd2, 4);
    expect_step("s3_7", 4'b0010, 1'b0, 2'd2, 4);

    // 4: BLINK, then two back-to-back requests: last wins, one ack, pattern restarts
    req(2'd3);
    expect_step("s4_apply", 4'b1111, 1'b1, 2'd3, 0);
    req(2'd2);
    req(2'd3);
    expect_step("s4_last_wins", 4'b1111, 1'b1, 2'd3, 0);
    expect_step("s4_blink", 4'b0000, 1'b0, 2'd3, 4);

    // 5: pause freezes everything; a request made while paused lands after release
    req(2'd1);
    expect_step("s5_apply", 4'b0001, 1'b1, 2'd1, 0);
    expect_step("s5_a", 4'b0010, 1'b0, 2'd1, 4);
    expect_step("s5_b", 4'b0100, 1'b0, 2'd1, 4);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mode_req = (i == 3);
      mode_sel = 2'd0;
      @(negedge clk);
      check("s5_frozen_led", {4'd0, led}, 8'h04);
      check("s5_no_step", {7'd0, step_tick}, 8'd0);
      check("s5_no_ack", {7'd0, mode_ack}, 8'd0);
    end
    mode_req = 1'b0;
    pause = 1'b0;
    expect_step("s5_resume", 4'b0000, 1'b1, 2'd0, 4);

    // 6: request on the tick cycle is deferred one step; reset drops a pending request
    req(2'd1);
    expect_step("s6_shift", 4'b0001, 1'b1, 2'd1, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    mode_req = 1'b1;
    mode_sel = 2'd3;
    @(negedge clk);
    mode_req = 1'b0;
    check("s6_tick_step", {7'd0, step_tick}, 8'd1);
    check("s6_tick_led", {4'd0, led}, 8'h02);
    check("s6_tick_noack", {7'd0, mode_ack}, 8'd0);
    check("s6_tick_mode", {6'd0, cur_mode}, 8'd1);
    expect_step("s6_deferred", 4'b1111, 1'b1, 2'd3, 4);
    req(2'd2);
    do_reset("s6");
    expect_step("s6_dropped", 4'b0000, 1'b0, 2'd0, 4);
    expect_step("s6_off", 4'b0000, 1'b0, 2'd0, 4);

    check("queue_empty", exp_q.size(), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
